mux_rr_sel: RTL and testbench

Round-robin select sequencer that drives the 2-bit select of the 4-to-1, 4-bit data multiplexer. It arbitrates among four requesting sources and presents a registered, glitch-free select together with a valid/ready handshake toward the downstream consumer of the mux output. A one-cycle acknowledge goes back to the served source, and a wrapping transfer counter tracks completed transfers. Sits directly upstream of the mux and owns its `sel` input.

---
 rtl/mux_rr_sel.sv | 177 +++++++++++++++++
 tb/tb_mux_rr_sel.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_sel.sv
// -----------------------------------------------------------------------------
// mux_rr_sel
//
// Purpose:
//   Round-robin select sequencer for a 4-to-1 data multiplexer. It arbitrates
//   among four level requesters and offers the chosen mux input downstream with
//   a valid/ready handshake. The mux select is registered and changes only when
//   an offer starts or a transfer completes, so the mux output never glitches
//   while it is being offered. The served source gets a one-cycle acknowledge
//   after its transfer, and a wrapping counter tracks completed transfers.
//
// Ports:
//   clk_i       in   1      single clock, rising edge
//   rst_ni      in   1      synchronous active-low reset
//   req_i       in   4      level request per source (bit k = mux input k)
//   ready_i     in   1      downstream accepts the offered data this cycle
//   sel_o       out  2      registered mux select
//   grant_o     out  4      one-hot copy of sel_o while valid_o is high, else 0
//   valid_o     out  1      sel_o / mux output offered downstream
//   ack_o       out  4      one-cycle pulse to the source served on the last edge
//   xfer_cnt_o  out  CNT_W  completed transfer count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module mux_rr_sel #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [3:0]       req_i,
  input  logic             ready_i,
  output logic [1:0]       sel_o,
  output logic [3:0]       grant_o,
  output logic             valid_o,
  output logic [3:0]       ack_o,
  output logic [CNT_W-1:0] xfer_cnt_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  // Round-robin pick: returns {found, index} of the first set bit of req in the
  // order last+1, last+2, last+3, last (mod 4). The loop walks the order
  // backwards so the earliest candidate overwrites later ones.
  function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // One-hot decode of a 2-bit index.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [3:0]       ack_q, ack_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       arb_req_s;
  logic [1:0]       arb_last_s;
  logic             arb_hit_s;
  logic [1:0]       arb_idx_s;

  // Arbitration inputs. In OFFER the decision is only used on a transfer, at
  // which point the pointer becomes sel and the served source is masked out for
  // this one decision; in IDLE the plain requests are searched from ptr.
  always_comb begin
    arb_req_s  = req_i;
    arb_last_s = ptr_q;
    if (state_q == ST_OFFER) begin
      arb_req_s  = req_i & ~grant_q;
      arb_last_s = sel_q;
    end else begin
      arb_req_s  = req_i;
      arb_last_s = ptr_q;
    end
    {arb_hit_s, arb_idx_s} = rr_pick(arb_req_s, arb_last_s);
  end

  // Next-state logic for the IDLE/OFFER handshake FSM and its outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    ack_d   = 4'b0000;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_hit_s) begin
          state_d = ST_OFFER;
          sel_d   = arb_idx_s;
          grant_d = onehot4(arb_idx_s);
          valid_d = 1'b1;
        end else begin
          // sel keeps its last value so the mux input does not move.
          grant_d = 4'b0000;
          valid_d = 1'b0;
        end
      end
      ST_OFFER: begin
        if (ready_i) begin
          ptr_d = sel_q;
          cnt_d = cnt_q + CNT_W'(1);
          ack_d = grant_q;
          if (arb_hit_s) begin
            // Back-to-back transfer: next offer starts on the same edge.
            state_d = ST_OFFER;
            sel_d   = arb_idx_s;
            grant_d = onehot4(arb_idx_s);
            valid_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            grant_d = 4'b0000;
            valid_d = 1'b0;
          end
        end else begin
          // An offer is never retracted, even if its request drops.
          state_d = ST_OFFER;
          sel_d   = sel_q;
          grant_d = grant_q;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset; ptr resets to
  // 3 so that source 0 has first priority.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd3;
      sel_q   <= 2'd0;
      grant_q <= 4'b0000;
      valid_q <= 1'b0;
      ack_q   <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel_o      = sel_q;
  assign grant_o    = grant_q;
  assign valid_o    = valid_q;
  assign ack_o      = ack_q;
  assign xfer_cnt_o = cnt_q;

endmodule

// File: tb/tb_mux_rr_sel.sv
// Bench for mux_rr_sel: two instances (CNT_W = 8 and CNT_W = 2) share the same
// stimulus. A directed vector table, a hand-written hold sequence and a random
// phase checked against a behavioural model.
module tb_mux_rr_sel;

  logic       clk;
  logic       rst_n_s;
  logic [3:0] req_s;
  logic       ready_s;

  logic [1:0] sel8, sel2;
  logic [3:0] grant8, grant2, ack8, ack2;
  logic       valid8, valid2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int n_total = 0;
  int n_pass  = 0;

  mux_rr_sel u_dut8 (
    .clk_i(clk), .rst_ni(rst_n_s), .req_i(req_s), .ready_i(ready_s),
    .sel_o(sel8), .grant_o(grant8), .valid_o(valid8), .ack_o(ack8),
    .xfer_cnt_o(cnt8)
  );

  mux_rr_sel #(.CNT_W(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n_s), .req_i(req_s), .ready_i(ready_s),
    .sel_o(sel2), .grant_o(grant2), .valid_o(valid2), .ack_o(ack2),
    .xfer_cnt_o(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // offered source index (-1 = nothing offered), last served source, counts
  int         m_offer;
  int         m_last;
  int         m_sel;
  int         m_cnt;
  logic [3:0] m_ack;

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (last + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge();
    if (!rst_n_s) begin
      m_offer = -1; m_last = 3; m_sel = 0; m_cnt = 0; m_ack = 4'b0000;
    end else begin
      m_ack = 4'b0000;
      if (m_offer >= 0) begin
        if (ready_s) begin
          m_ack   = 4'(1 << m_offer);
          m_cnt   = m_cnt + 1;
          m_last  = m_offer;
          m_offer = pick(req_s & ~m_ack, m_last);
          if (m_offer >= 0) m_sel = m_offer;
        end
      end else begin
        m_offer = pick(req_s, m_last);
        if (m_offer >= 0) m_sel = m_offer;
      end
    end
  endtask

  // advance one clock (model follows the DUT edge), then settle before sampling
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string nm, input logic v, input logic [1:0] s,
                       input logic [3:0] g, input logic [3:0] a,
                       input logic [7:0] c);
    n_total++;
    if ({valid8, sel8, grant8, ack8, cnt8} === {v, s, g, a, c}) n_pass++;
    else $display("FAIL %s w8: got v=%b sel=%0d g=%b ack=%b cnt=%0d, want v=%b sel=%0d g=%b ack=%b cnt=%0d",
                  nm, valid8, sel8, grant8, ack8, cnt8, v, s, g, a, c);
    n_total++;
    if ({valid2, sel2, grant2, ack2, cnt2} === {v, s, g, a, c[1:0]}) n_pass++;
    else $display("FAIL %s w2: got v=%b sel=%0d g=%b ack=%b cnt=%0d, want v=%b sel=%0d g=%b ack=%b cnt=%0d",
                  nm, valid2, sel2, grant2, ack2, cnt2, v, s, g, a, c[1:0]);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rdy;
    logic       v;
    logic [1:0] sel;
    logic [3:0] g;
    logic [3:0] a;
    logic [7:0] c;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic y,
                              input logic v, input logic [1:0] s,
                              input logic [3:0] g, input logic [3:0] a,
                              input logic [7:0] c);
    vec_t t;
    t.rst_n = r; t.req = q; t.rdy = y; t.v = v; t.sel = s; t.g = g; t.a = a; t.c = c;
    return t;
  endfunction

  initial begin
    // reset held with all requesting and ready high
    tbl[0]  = mk(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 8'd0);
    tbl[1]  = mk(1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 8'd0);
    // release: source 0 first, then round robin 1,2,3,0,1
    tbl[2]  = mk(1'b1, 4'hF, 1'b1, 1'b1, 2'd0, 4'h1, 4'h0, 8'd0);
    tbl[3]  = mk(1'b1, 4'hF, 1'b1, 1'b1, 2'd1, 4'h2, 4'h1, 8'd1);
    tbl[4]  = mk(1'b1, 4'hF, 1'b1, 1'b1, 2'd2, 4'h4, 4'h2, 8'd2);
    tbl[5]  = mk(1'b1, 4'hF, 1'b1, 1'b1, 2'd3, 4'h8, 4'h4, 8'd3);
    tbl[6]  = mk(1'b1, 4'hF, 1'b1, 1'b1, 2'd0, 4'h1, 4'h8, 8'd4);
    tbl[7]  = mk(1'b1, 4'hF, 1'b1, 1'b1, 2'd1, 4'h2, 4'h1, 8'd5);
    // drain source 1 to IDLE
    tbl[8]  = mk(1'b1, 4'h0, 1'b1, 1'b0, 2'd1, 4'h0, 4'h2, 8'd6);
    // backpressure on source 2
    tbl[9]  = mk(1'b1, 4'h4, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0, 8'd6);
    tbl[10] = mk(1'b1, 4'h4, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0, 8'd6);
    tbl[11] = mk(1'b1, 4'h4, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0, 8'd6);
    tbl[12] = mk(1'b1, 4'h4, 1'b0, 1'b1, 2'd2, 4'h4, 4'h0, 8'd6);
    tbl[13] = mk(1'b1, 4'h4, 1'b1, 1'b0, 2'd2, 4'h0, 4'h4, 8'd7);
    tbl[14] = mk(1'b1, 4'h0, 1'b1, 1'b0, 2'd2, 4'h0, 4'h0, 8'd7);
    // sole requester 1: valid 1,0,1,0
    tbl[15] = mk(1'b1, 4'h2, 1'b1, 1'b1, 2'd1, 4'h2, 4'h0, 8'd7);
    tbl[16] = mk(1'b1, 4'h2, 1'b1, 1'b0, 2'd1, 4'h0, 4'h2, 8'd8);
    tbl[17] = mk(1'b1, 4'h2, 1'b1, 1'b1, 2'd1, 4'h2, 4'h0, 8'd8);
    tbl[18] = mk(1'b1, 4'h0, 1'b1, 1'b0, 2'd1, 4'h0, 4'h2, 8'd9);
    // skip and wrap: serve 2, then req 0101 gives 0 then 2
    tbl[19] = mk(1'b1, 4'h4, 1'b1, 1'b1, 2'd2, 4'h4, 4'h0, 8'd9);
    tbl[20] = mk(1'b1, 4'h5, 1'b1, 1'b1, 2'd0, 4'h1, 4'h4, 8'd10);
    tbl[21] = mk(1'b1, 4'h5, 1'b1, 1'b1, 2'd2, 4'h4, 4'h1, 8'd11);
    tbl[22] = mk(1'b1, 4'h0, 1'b1, 1'b0, 2'd2, 4'h0, 4'h4, 8'd12);
    // mid-offer reset beats ready: no ack, count cleared
    tbl[23] = mk(1'b1, 4'h8, 1'b0, 1'b1, 2'd3, 4'h8, 4'h0, 8'd12);
    tbl[24] = mk(1'b0, 4'h8, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 8'd0);
    tbl[25] = mk(1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 8'd0);

    rst_n_s = 1'b0; req_s = 4'h0; ready_s = 1'b0;
    m_offer = -1; m_last = 3; m_sel = 0; m_cnt = 0; m_ack = 4'b0000;

    for (int i = 0; i < 26; i++) begin
      rst_n_s = tbl[i].rst_n; req_s = tbl[i].req; ready_s = tbl[i].rdy;
      step();
      check($sformatf("tbl[%0d]", i), tbl[i].v, tbl[i].sel, tbl[i].g, tbl[i].a, tbl[i].c);
    end

    // hand sequence: offer held while its request drops, then one transfer
    req_s = 4'h1; ready_s = 1'b0;
    step();
    check("hold_start", 1'b1, 2'd0, 4'h1, 4'h0, 8'd0);
    req_s = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold_drop%0d", i), 1'b1, 2'd0, 4'h1, 4'h0, 8'd0);
    end
    ready_s = 1'b1;
    step();
    check("hold_xfer", 1'b0, 2'd0, 4'h0, 4'h1, 8'd1);
    step();
    check("hold_after", 1'b0, 2'd0, 4'h0, 4'h0, 8'd1);

    // random phase against the model
    for (int i = 0; i < 400; i++) begin
      rst_n_s = ($urandom_range(0, 59) != 0);
      req_s   = 4'($urandom_range(0, 15));
      ready_s = ($urandom_range(0, 3) != 0);
      step();
      check($sformatf("rand[%0d]", i), (m_offer >= 0), 2'(m_sel),
            (m_offer >= 0) ? 4'(1 << m_offer) : 4'h0, m_ack, 8'(m_cnt));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
